// File: rtl/hex_ascii_decoder.sv
// Assembles pairs of ASCII hex digits from a UART character stream into bytes behind a one-entry valid/ready register.
// Build option: define HEX_ASCII_DECODER_LOWERCASE_EN to accept 'a'-'f' as hex digits.
module hex_ascii_decoder #(
    parameter int unsigned FLUSH_ON_SEP = 1,
    parameter int unsigned COUNT_W      = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               out_valid,
    output logic [7:0]         out_data,
    input  logic               out_ready,
    output logic               err_char,
    output logic               err_overflow,
    output logic               pending,
    output logic [COUNT_W-1:0] byte_count
);

    typedef enum logic {
        EMPTY   = 1'b0,
        HAVE_HI = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [3:0]         hi_nib, hi_nib_next;
    logic               out_valid_next;
    logic [7:0]         out_data_next;
    logic               err_char_next;
    logic               err_overflow_next;
    logic [COUNT_W-1:0] byte_count_next;

    logic       is_digit;
    logic       is_sep;
    logic [3:0] nib;
    logic       complete;
    logic [7:0] byte_val;
    logic       out_free;

    always_comb begin
        is_digit = 1'b0;
        is_sep   = 1'b0;
        nib      = '0;
        if (in_data >= 8'h30 && in_data <= 8'h39) begin
            is_digit = 1'b1;
            nib      = in_data[3:0];
        end else if (in_data >= 8'h41 && in_data <= 8'h46) begin
            is_digit = 1'b1;
            nib      = in_data[3:0] + 4'd9;
`ifdef HEX_ASCII_DECODER_LOWERCASE_EN
        end else if (in_data >= 8'h61 && in_data <= 8'h66) begin
            is_digit = 1'b1;
            nib      = in_data[3:0] + 4'd9;
`endif
        end else if (in_data == 8'h20 || in_data == 8'h0D ||
                     in_data == 8'h0A || in_data == 8'h2C) begin
            is_sep = 1'b1;
        end
    end

    always_comb begin
        state_next    = state;
        hi_nib_next   = hi_nib;
        complete      = 1'b0;
        byte_val      = '0;
        err_char_next = 1'b0;

        if (in_valid) begin
            unique case (state)
                EMPTY: begin
                    if (is_digit) begin
                        hi_nib_next = nib;
                        state_next  = HAVE_HI;
                    end else if (!is_sep) begin
                        err_char_next = 1'b1;
                    end
                end
                HAVE_HI: begin
                    state_next = EMPTY;
                    if (is_digit) begin
                        complete = 1'b1;
                        byte_val = {hi_nib, nib};
                    end else if (is_sep) begin
                        if (FLUSH_ON_SEP != 0) begin
                            complete = 1'b1;
                            byte_val = {4'h0, hi_nib};
                        end
                    end else begin
                        err_char_next = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end

        // A consume and a new load may land on the same edge.
        out_free          = !out_valid || out_ready;
        out_valid_next    = out_valid && !out_ready;
        out_data_next     = out_data;
        byte_count_next   = byte_count;
        err_overflow_next = 1'b0;
        if (complete) begin
            if (out_free) begin
                out_valid_next  = 1'b1;
                out_data_next   = byte_val;
                byte_count_next = byte_count + COUNT_W'(1);
            end else begin
                err_overflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= EMPTY;
            hi_nib       <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            err_char     <= 1'b0;
            err_overflow <= 1'b0;
            byte_count   <= '0;
        end else begin
            state        <= state_next;
            hi_nib       <= hi_nib_next;
            out_valid    <= out_valid_next;
            out_data     <= out_data_next;
            err_char     <= err_char_next;
            err_overflow <= err_overflow_next;
            byte_count   <= byte_count_next;
        end
    end

    assign pending = (state == HAVE_HI);

endmodule
